// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared action codes, state encoding and depth for the pio configuration loader
package pio_pkg;

    localparam int NPROG = 32;

    localparam logic [3:0] ACT_NOP   = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_WRAP  = 4'd2;
    localparam logic [3:0] ACT_PINS  = 4'd5;
    localparam logic [3:0] ACT_EN    = 4'd6;
    localparam logic [3:0] ACT_DIV   = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_INSTR,
        ST_WRAP,
        ST_DIV,
        ST_PINS,
        ST_EN,
        ST_FIN
    } state_t;

endpackage

// File: rtl/pio_cfg_loader.sv
// rtl/pio_cfg_loader.sv - streams a program image and setup writes into the pio configuration port
module pio_cfg_loader
    import pio_pkg::*;
#(
    parameter int HOLD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  plen,
    input  logic [1:0]  mindex_cfg,
    input  logic [4:0]  wrap_top,
    input  logic [23:0] div,
    input  logic [31:0] pin_grps,
    input  logic [3:0]  en_mask,
    output logic [4:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [3:0]  action,
    output logic [4:0]  index,
    output logic [1:0]  mindex,
    output logic [31:0] din,
    output logic        busy,
    output logic        done
);

    localparam int HW = $clog2(HOLD) + 1;
    localparam logic [HW-1:0] RELOAD = HW'(HOLD - 1);

    state_t        r_state;
    logic [HW-1:0] r_hold;
    logic [4:0]    r_cnt;
    logic [4:0]    r_last;
    logic [1:0]    r_mcfg;
    logic [4:0]    r_wrap_top;
    logic [23:0]   r_div;
    logic [31:0]   r_pins;
    logic [3:0]    r_en;

    logic [4:0]    r_rom_addr;
    logic [3:0]    r_action;
    logic [4:0]    r_index;
    logic [1:0]    r_mindex;
    logic [31:0]   r_din;
    logic          r_busy;
    logic          r_done;

    logic [4:0]    w_last;
    logic [4:0]    w_wrap_idx;
    logic [1:0]    w_wrap_mi;

    // Index of the final instruction after clamping the length to the memory depth.
    assign w_last = (plen >= 6'(NPROG)) ? 5'(NPROG - 1) : (plen[4:0] - 5'd1);

    // WRAP is entered either straight from IDLE (plen=0, use live inputs) or after INSTR (latched copies).
    assign w_wrap_idx = (r_state == ST_IDLE) ? wrap_top   : r_wrap_top;
    assign w_wrap_mi  = (r_state == ST_IDLE) ? mindex_cfg : r_mcfg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_cnt      <= '0;
            r_last     <= '0;
            r_mcfg     <= '0;
            r_wrap_top <= '0;
            r_div      <= '0;
            r_pins     <= '0;
            r_en       <= '0;
            r_rom_addr <= '0;
            r_action   <= ACT_NOP;
            r_index    <= '0;
            r_mindex   <= '0;
            r_din      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcfg     <= mindex_cfg;
                        r_wrap_top <= wrap_top;
                        r_div      <= div;
                        r_pins     <= pin_grps;
                        r_en       <= en_mask;
                        r_last     <= w_last;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        if (plen == 6'd0) begin
                            r_state  <= ST_WRAP;
                            r_action <= ACT_WRAP;
                            r_index  <= w_wrap_idx;
                            r_mindex <= w_wrap_mi;
                            r_hold   <= RELOAD;
                        end else begin
                            r_state    <= ST_FETCH;
                            r_action   <= ACT_NOP;
                            r_rom_addr <= '0;
                        end
                    end
                end
                ST_FETCH: begin
                    r_state  <= ST_INSTR;
                    r_action <= ACT_INSTR;
                    r_index  <= r_cnt;
                    r_din    <= {16'h0, rom_data};
                    r_hold   <= RELOAD;
                end
                ST_INSTR: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == r_last) begin
                            r_state  <= ST_WRAP;
                            r_action <= ACT_WRAP;
                            r_index  <= w_wrap_idx;
                            r_mindex <= w_wrap_mi;
                            r_hold   <= RELOAD;
                        end else begin
                            r_state    <= ST_FETCH;
                            r_action   <= ACT_NOP;
                            r_rom_addr <= r_cnt + 5'd1;
                        end
                    end
                end
                ST_WRAP: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - 1'b1;
                    end else begin
                        r_state  <= ST_DIV;
                        r_action <= ACT_DIV;
                        r_din    <= {8'h0, r_div};
                        r_hold   <= RELOAD;
                    end
                end
                ST_DIV: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - 1'b1;
                    end else begin
                        r_state  <= ST_PINS;
                        r_action <= ACT_PINS;
                        r_din    <= r_pins;
                        r_hold   <= RELOAD;
                    end
                end
                ST_PINS: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - 1'b1;
                    end else begin
                        r_state  <= ST_EN;
                        r_action <= ACT_EN;
                        r_din    <= {28'h0, r_en};
                        r_hold   <= RELOAD;
                    end
                end
                ST_EN: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - 1'b1;
                    end else begin
                        r_state  <= ST_FIN;
                        r_action <= ACT_NOP;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr = r_rom_addr;
    assign action   = r_action;
    assign index    = r_index;
    assign mindex   = r_mindex;
    assign din      = r_din;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_pio_cfg_loader.sv
// tb/tb_pio_cfg_loader.sv - scoreboard bench driving HOLD=2 and HOLD=1 loaders from shared stimulus
module tb_pio_cfg_loader;

    typedef struct {
        logic [3:0]  act;
        logic [4:0]  idx;
        logic [31:0] din;
        logic [1:0]  mi;
        bit          chk_din;
        bit          chk_mi;
    } wr_t;

    typedef struct {
        int         busy_cycles;
        logic [4:0] addr;
    } fin_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  plen = '0;
    logic [1:0]  mindex_cfg = '0;
    logic [4:0]  wrap_top = '0;
    logic [23:0] div = '0;
    logic [31:0] pin_grps = '0;
    logic [3:0]  en_mask = '0;

    logic [4:0]  rom_addr [2];
    logic [15:0] rom_data [2];
    logic [3:0]  action   [2];
    logic [4:0]  index    [2];
    logic [1:0]  mindex   [2];
    logic [31:0] din      [2];
    logic        busy     [2];
    logic        done     [2];

    logic [15:0] rom [32];
    wr_t         exp_q [2][$];
    fin_t        fin_q [2][$];
    int          ndone [2];
    logic [4:0]  last_addr = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    function automatic int hold_of(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        assign rom_data[g] = rom[rom_addr[g]];

        pio_cfg_loader #(.HOLD((g == 0) ? 2 : 1)) dut (
            .clk(clk), .reset(reset), .start(start), .plen(plen),
            .mindex_cfg(mindex_cfg), .wrap_top(wrap_top), .div(div),
            .pin_grps(pin_grps), .en_mask(en_mask), .rom_addr(rom_addr[g]),
            .rom_data(rom_data[g]), .action(action[g]), .index(index[g]),
            .mindex(mindex[g]), .din(din[g]), .busy(busy[g]), .done(done[g])
        );

        logic [3:0]  ra;
        logic [4:0]  ri;
        logic [31:0] rd;
        logic [1:0]  rm;
        int          rlen;
        bit          in_run = 1'b0;
        int          bcnt = 0;

        // Collapse each run of one non-zero action into a single write record.
        always @(negedge clk) begin
            if (!reset) begin
                in_run = 1'b0;
                bcnt   = 0;
            end else begin
                if (in_run && action[g] == ra) begin
                    rlen++;
                    n_cmp++;
                    if (index[g] != ri || din[g] != rd || mindex[g] != rm) begin
                        n_bad++;
                        $display("FAIL stable[%0d] act=%0d idx=%0d din=%h mi=%0d changed from idx=%0d din=%h mi=%0d",
                                 g, action[g], index[g], din[g], mindex[g], ri, rd, rm);
                    end
                end else begin
                    if (in_run) check_run(g, ra, ri, rd, rm, rlen);
                    in_run = (action[g] != 4'd0);
                    ra = action[g]; ri = index[g]; rd = din[g]; rm = mindex[g]; rlen = 1;
                end
                if (busy[g]) bcnt++;
                if (done[g]) begin
                    check_fin(g, bcnt, rom_addr[g], busy[g]);
                    bcnt = 0;
                    ndone[g]++;
                end
            end
        end
    end

    task automatic check_run(input int g, input logic [3:0] a, input logic [4:0] i,
                             input logic [31:0] d, input logic [1:0] m, input int len);
        wr_t e;
        n_cmp++;
        if (exp_q[g].size() == 0) begin
            n_bad++;
            $display("FAIL write[%0d] unexpected act=%0d idx=%0d din=%h len=%0d, required no write", g, a, i, d, len);
        end else begin
            e = exp_q[g].pop_front();
            if (a != e.act || i != e.idx || (e.chk_din && d != e.din) ||
                (e.chk_mi && m != e.mi) || len != hold_of(g)) begin
                n_bad++;
                $display("FAIL write[%0d] got act=%0d idx=%0d din=%h mi=%0d len=%0d, required act=%0d idx=%0d din=%h mi=%0d len=%0d",
                         g, a, i, d, m, len, e.act, e.idx, e.din, e.mi, hold_of(g));
            end
        end
    endtask

    task automatic check_fin(input int g, input int bc, input logic [4:0] addr, input logic b);
        fin_t f;
        n_cmp++;
        if (fin_q[g].size() == 0) begin
            n_bad++;
            $display("FAIL done[%0d] unexpected pulse busy_cycles=%0d, required none", g, bc);
        end else begin
            f = fin_q[g].pop_front();
            if (bc != f.busy_cycles || addr != f.addr || b != 1'b0 || exp_q[g].size() != 0) begin
                n_bad++;
                $display("FAIL done[%0d] busy_cycles=%0d rom_addr=%0d busy=%0d pending=%0d, required %0d %0d 0 0",
                         g, bc, addr, b, exp_q[g].size(), f.busy_cycles, f.addr);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Reference model: what the pio port must see for one accepted start.
    task automatic push_expect(input int p, input logic [1:0] mc, input logic [4:0] wt,
                               input logic [23:0] dv, input logic [31:0] pg, input logic [3:0] en);
        int n = (p > 32) ? 32 : p;
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < n; i++)
                exp_q[g].push_back('{4'd1, 5'(i), {16'h0, rom[i]}, 2'd0, 1'b1, 1'b0});
            exp_q[g].push_back('{4'd2, wt, 32'h0, mc, 1'b0, 1'b1});
            exp_q[g].push_back('{4'd7, wt, {8'h0, dv}, mc, 1'b1, 1'b1});
            exp_q[g].push_back('{4'd5, wt, pg, mc, 1'b1, 1'b1});
            exp_q[g].push_back('{4'd6, wt, {28'h0, en}, mc, 1'b1, 1'b1});
            fin_q[g].push_back('{n * (1 + hold_of(g)) + 4 * hold_of(g), (n > 0) ? 5'(n - 1) : last_addr});
        end
        if (n > 0) last_addr = 5'(n - 1);
    endtask

    task automatic launch(input int p, input logic [1:0] mc, input logic [4:0] wt,
                          input logic [23:0] dv, input logic [31:0] pg, input logic [3:0] en);
        push_expect(p, mc, wt, dv, pg, en);
        @(negedge clk); #1;
        plen = 6'(p); mindex_cfg = mc; wrap_top = wt; div = dv; pin_grps = pg; en_mask = en;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int n1);
        int k = 0;
        while ((ndone[0] == n0 || ndone[1] == n1) && k < 3000) begin
            @(posedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 3000) begin
            n_bad++;
            $display("FAIL timeout waiting for done, got done counts %0d/%0d required %0d/%0d", ndone[0], ndone[1], n0 + 1, n1 + 1);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic run(input int p, input logic [1:0] mc, input logic [4:0] wt,
                       input logic [23:0] dv, input logic [31:0] pg, input logic [3:0] en);
        int n0 = ndone[0];
        int n1 = ndone[1];
        launch(p, mc, wt, dv, pg, en);
        wait_done(n0, n1);
    endtask

    initial begin
        int n0, n1, k;
        ndone[0] = 0;
        ndone[1] = 0;
        for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
        rom[0] = 16'hE081; rom[1] = 16'hE101; rom[2] = 16'hE000; rom[3] = 16'h0001;

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("rst_action", 32'(action[g]), 32'd0);
            check("rst_index", 32'(index[g]), 32'd0);
            check("rst_mindex", 32'(mindex[g]), 32'd0);
            check("rst_din", din[g], 32'd0);
            check("rst_rom_addr", 32'(rom_addr[g]), 32'd0);
            check("rst_busy_done", {30'd0, busy[g], done[g]}, 32'd0);
        end
        @(negedge clk); reset = 1'b1;
        repeat (2) @(posedge clk);

        run(4, 2'd1, 5'd3, 24'h280, 32'h1, 4'h1);
        run(0, 2'd2, 5'd7, 24'h12345, 32'hDEADBEEF, 4'hA);
        run(40, 2'd3, 5'd31, 24'hABCDEF, 32'h0F0F0F0F, 4'hF);

        // Re-start and input changes after acceptance must not disturb the running load.
        n0 = ndone[0]; n1 = ndone[1];
        launch(8, 2'd1, 5'd9, 24'h000100, 32'h55AA55AA, 4'h3);
        repeat (3) @(negedge clk);
        #1;
        start = 1'b1; plen = 6'd2; mindex_cfg = 2'd3; wrap_top = 5'd1;
        div = 24'hFFFFFF; pin_grps = 32'h0; en_mask = 4'h0;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(n0, n1);
        repeat (40) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) check("no_second_seq", {31'd0, busy[g]}, 32'd0);

        // Reset while the HOLD=2 loader is in DIV abandons both.
        launch(4, 2'd2, 5'd5, 24'h777, 32'h1234, 4'h5);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (action[0] != 4'd7 && k < 500);
        check("reach_div", 32'(action[0]), 32'd7);
        #1;
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            exp_q[g].delete();
            fin_q[g].delete();
        end
        last_addr = '0;
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) begin
            check("mid_rst_action", 32'(action[g]), 32'd0);
            check("mid_rst_busy_done", {30'd0, busy[g], done[g]}, 32'd0);
        end
        @(negedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        run(4, 2'd2, 5'd5, 24'h777, 32'h1234, 4'h5);

        for (int t = 0; t < 6; t++)
            run($urandom_range(0, 40), 2'($urandom), 5'($urandom), 24'($urandom),
                32'($urandom), 4'($urandom));

        repeat (10) @(posedge clk);
        for (int g = 0; g < 2; g++) begin
            check("left_writes", 32'(exp_q[g].size()), 32'd0);
            check("left_dones", 32'(fin_q[g].size()), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pio_cfg_loader.md
Name: pio_cfg_loader

Overview:
Autonomous configuration initiator for the pio block. It drives pio's action/index/mindex/din configuration port so the program and setup are loaded in hardware, without a CPU or bench doing it.
- On start, it streams a program image from an external instruction ROM, then issues wrap, clock-divider, pin-group and enable writes.
- It then returns the port to action 0 (no-op).
- It sits between a boot/reset controller and the pio instance.

Parameters:
HOLD, 2, cycles each non-idle action/index/din word is held stable (>=1)
NPROG, 32, instruction memory depth (index width 5)

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-low (0 = reset)
start  in  1  single-cycle request to begin a load sequence
plen  in  6  program length in instructions (0..32)
mindex_cfg  in  2  target state machine for wrap/div/pins/enable writes
wrap_top  in  5  wrap target index
div  in  24  fractional clock divider, 16.8 format
pin_grps  in  32  packed pin-group word
en_mask  in  4  machine enable mask, zero-extended into din
rom_addr  out  5  instruction ROM read address
rom_data  in  16  instruction ROM data, valid one cycle after rom_addr
action  out  4  pio configuration action code
index  out  5  pio instruction/wrap index
mindex  out  2  pio machine select
din  out  32  pio configuration data
busy  out  1  high from the cycle after start acceptance until the sequence ends
done  out  1  one-cycle pulse when the sequence completes

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE
  - action=0, index=0, mindex=0, din=0, rom_addr=0, busy=0, done=0
  - holdcnt=0, instruction counter=0
  - Reset mid-sequence abandons the load immediately. No partial write is repeated or completed.
- Start acceptance:
  - start is accepted only in IDLE. Call that edge T.
  - plen, mindex_cfg, wrap_top, div, pin_grps and en_mask are latched at T.
  - Input changes after T have no effect.
  - start while busy is ignored and is not queued.
- Length handling: plen>32 is clamped to 32. plen=0 skips program loading and goes directly to WRAP.
- States: IDLE, FETCH, INSTR, WRAP, DIV, PINS, EN, FIN.
- FETCH (1 cycle):
  - rom_addr=i, action=0.
  - Next state is INSTR.
- INSTR (HOLD cycles):
  - Register on entry: action=1, index=i, din={16'h0, rom_data}. rom_data is sampled at the entry edge.
  - index, din and mindex are held constant for all HOLD cycles.
  - On exit, i increments. If i==plen_latched-1 the next state is WRAP, otherwise FETCH.
- WRAP (HOLD cycles): action=2, index=wrap_top, mindex=mindex_cfg.
- DIV (HOLD cycles): action=7, din={8'h0, div}.
- PINS (HOLD cycles): action=5, din=pin_grps.
- EN (HOLD cycles): action=6, din={28'h0, en_mask}.
- FIN (1 cycle):
  - action=0, busy=0, done=1.
  - Next state is IDLE, where done returns to 0.
  - index, mindex and din retain their last values.
- Busy window:
  - busy=1 in FETCH through EN.
  - Total busy cycles = clamp(plen)*(1+HOLD) + 4*HOLD.
- Signal stability:
  - Outputs change only at action boundaries.
  - action never glitches between two non-zero codes without either HOLD cycles of stability or an intervening 0.
  - All outputs are registered.
- Hold counter:
  - Width is clog2(HOLD)+1.
  - Reloaded to HOLD-1 on state entry.
  - The state advances when the counter reads 0.
- Simultaneous events: start and reset asserted together means reset wins.

Decomposition:
Shared package pio_pkg, containing:
- localparams for action codes: ACT_NOP=0, ACT_INSTR=1, ACT_WRAP=2, ACT_PINS=5, ACT_EN=6, ACT_DIV=7
- the state enumeration
- NPROG

No sub-module is required. The hold counter stays inline as a small counter.

Test Plan:
1. Basic load, ROM={E081,E101,E000,0001}, plen=4, HOLD=2, wrap_top=3, div=24'h280, pin_grps=1, en_mask=1, start pulse.
   - Required: 4 action=1 bursts at index 0..3 with din=0000E081, 0000E101, 0000E000, 00000001.
   - Then action 2/7/5/6 with index=3, din=00000280, 00000001, 00000001.
   - busy high exactly 20 cycles, then a single done pulse.
2. plen=0, start.
   - Required: no action=1 and no rom_addr change.
   - WRAP/DIV/PINS/EN follow; busy=8 cycles with HOLD=2.
3. plen=40.
   - Required: exactly 32 instruction writes (index 0..31), then WRAP.
4. Second start pulse mid-INSTR, and config inputs changed after T.
   - Required: the sequence is unaffected, with no second sequence afterward.
5. reset=0 asserted during DIV.
   - Required: the next cycle shows action=0, busy=0, done=0.
   - A new start afterward replays the full sequence from index 0.
6. HOLD=1 build.
   - Required: each configuration action lasts exactly 1 cycle.
   - Each instruction write is preceded by one action=0 FETCH cycle.
   - busy = 4*2+4 = 12 cycles for plen=4.
